moore_1101_framer: RTL

//  Serial frame transmitter: the sending end of the 1101 sync-recognizer link.

---
 rtl/moore_1101_framer.sv | 99 +++++++++
 1 files changed

// File: rtl/moore_1101_framer.sv
// rtl/moore_1101_framer.sv - serial frame transmitter: sync header, MSB-first payload, idle gap
// Every output is decoded from state, cnt and the shift registers, so nothing combinational reaches ser_out.
module moore_1101_framer #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1101,
    parameter int                GAP    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_ALL = (MAX_SD > GAP) ? MAX_SD : GAP;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    // With GAP=0 the GAP state is unreachable; the constant only needs to be legal.
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [SYNC_W-1:0] sync_sr;
    logic [DATA_W-1:0] data_sr;
    logic              accept;

    // reset_n gates ready so a producer never sees a handshake while the block is held in reset.
    assign load_ready  = (state == S_IDLE) && reset_n;
    assign accept      = load_valid && load_ready;
    assign ser_valid   = (state == S_SYNC) || (state == S_DATA);
    assign ser_out     = (state == S_SYNC) ? sync_sr[SYNC_W-1] :
                         (state == S_DATA) ? data_sr[DATA_W-1] : 1'b0;
    assign frame_start = (state == S_SYNC) && (cnt == '0);
    assign frame_done  = (state == S_DATA) && (cnt == DATA_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sync_sr <= '0;
            data_sr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_sr <= load_data;
                        sync_sr <= SYNC;
                        cnt     <= '0;
                        state   <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    sync_sr <= sync_sr << 1;
                    if (cnt == SYNC_LAST) begin
                        cnt   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    data_sr <= data_sr << 1;
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
